mem_arbiter: RTL and testbench

- Shares the single-port 8-bit RAM (bidirectional data bus, write enable, 8-bit address) between two requesters.
- Port 0 is the CPU; port 1 is a loader/DMA/debug master.
- Per-beat valid/grant handshake, round-robin fairness, optional locked bursts.
- Registers one access per cycle onto the memory bus and returns read data one cycle later.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port 8-bit RAM: round-robin grants, optional locked
// bursts, one registered access per cycle with read data returned one cycle later.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       lock0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       rvalid0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       lock1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       rvalid1,
    output logic [7:0] rdata1,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    inout  logic [7:0] mem_data
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {OPEN, LOCKED0, LOCKED1} state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          acc0, acc1;
    logic [7:0]    wdata_q;
    logic          rd_pend0, rd_pend1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            OPEN: begin
                // On a tie the port that did not win last time goes first.
                if (req0 && req1) begin
                    gnt0 = last;
                    gnt1 = !last;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
            LOCKED0: gnt0 = req0;
            LOCKED1: gnt1 = req1;
            default: ;
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign acc0 = req0 && gnt0;
    assign acc1 = req1 && gnt1;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        count_nxt = count;
        case (state)
            OPEN: begin
                if (acc0 || acc1) begin
                    last_nxt = acc1;
                    if ((MAX_BURST > 1) && ((acc0 && lock0) || (acc1 && lock1))) begin
                        state_nxt = acc0 ? LOCKED0 : LOCKED1;
                        count_nxt = CW'(1);
                    end
                end
            end
            LOCKED0: begin
                if (req0 && lock0 && (count < LAST_BEAT)) begin
                    count_nxt = count + CW'(1);
                end else begin
                    state_nxt = OPEN;
                    last_nxt  = 1'b0;
                    count_nxt = '0;
                end
            end
            LOCKED1: begin
                if (req1 && lock1 && (count < LAST_BEAT)) begin
                    count_nxt = count + CW'(1);
                end else begin
                    state_nxt = OPEN;
                    last_nxt  = 1'b1;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = OPEN;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= OPEN;
            last     <= 1'b1;
            count    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            wdata_q  <= '0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            count    <= count_nxt;
            mem_we   <= (acc0 && we0) || (acc1 && we1);
            if (acc0) begin
                mem_addr <= addr0;
                wdata_q  <= wdata0;
            end else if (acc1) begin
                mem_addr <= addr1;
                wdata_q  <= wdata1;
            end
            rd_pend0 <= acc0 && !we0;
            rd_pend1 <= acc1 && !we1;
            // Read data is on the bus during the cycle after acceptance.
            rvalid0  <= rd_pend0;
            rvalid1  <= rd_pend1;
            if (rd_pend0) rdata0 <= mem_data;
            if (rd_pend1) rdata1 <= mem_data;
        end
    end

    assign mem_data = mem_we ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model of arbitration, a shadow memory and a two-deep beat queue.
module tb_mem_arbiter;

    localparam int unsigned MAX_BURST = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, lock0 = 1'b0, we0 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0;
    logic       req1 = 1'b0, lock1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr1 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [7:0] rdata0, rdata1, mem_addr;
    wire  [7:0] mem_data;

    logic [7:0] ram [256];
    logic       ram_load = 1'b1;
    logic [7:0] shadow [256];

    int n_vec = 0;
    int n_err = 0;

    int         owner, beats, last, prev_win;
    bit         p1v, p1we, p2v, p2we;
    int         p1port, p2port;
    logic [7:0] p1addr, p1data, p2addr, p2data;
    logic [7:0] exp_rd0, exp_rd1, exp_addr;

    mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int a);
        return (a == 'h10) ? 8'h5A : 8'(a * 73 + 27);
    endfunction

    // Behavioural RAM: drives the bus whenever the arbiter is not writing.
    assign mem_data = mem_we ? 'z : ram[mem_addr];
    always @(posedge clock) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; beats = 0; last = 1; prev_win = -1;
        p1v = 0; p2v = 0; p1we = 0; p2we = 0;
        p1port = 0; p2port = 0;
        p1addr = '0; p1data = '0; p2addr = '0; p2data = '0;
        exp_rd0 = '0; exp_rd1 = '0; exp_addr = '0;
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        int win;
        bit lk;
        #1;
        win = -1;
        if (owner < 0) begin
            if (req0 && req1) win = (last == 0) ? 1 : 0;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
        end else if ((owner == 0 && req0) || (owner == 1 && req1)) begin
            win = owner;
        end
        check("gnt0", 32'(gnt0), 32'(win == 0));
        check("gnt1", 32'(gnt1), 32'(win == 1));

        if (p1v && p1we) shadow[p1addr] = p1data;
        p2v = p1v; p2we = p1we; p2port = p1port; p2addr = p1addr; p2data = p1data;
        p1v = (win >= 0);
        if (win >= 0) begin
            lk     = (win == 0) ? lock0 : lock1;
            p1port = win;
            p1we   = (win == 0) ? we0 : we1;
            p1addr = (win == 0) ? addr0 : addr1;
            p1data = p1we ? ((win == 0) ? wdata0 : wdata1) : shadow[p1addr];
            exp_addr = p1addr;
            if (owner < 0) begin
                last = win;
                if (lk && MAX_BURST > 1) begin
                    owner = win;
                    beats = 1;
                end
            end else begin
                beats++;
                if (!lk || beats == MAX_BURST) begin
                    last = owner; owner = -1; beats = 0;
                end
            end
        end else if (owner >= 0) begin
            last = owner; owner = -1; beats = 0;
        end
        prev_win = win;

        @(negedge clock);
        check("mem_we", 32'(mem_we), 32'(p1v && p1we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (p1v && p1we) check("mem_data", 32'(mem_data), 32'(p1data));
        if (p2v && !p2we) begin
            if (p2port == 0) exp_rd0 = p2data;
            else             exp_rd1 = p2data;
        end
        check("rvalid0", 32'(rvalid0), 32'(p2v && !p2we && p2port == 0));
        check("rvalid1", 32'(rvalid1), 32'(p2v && !p2we && p2port == 1));
        check("rdata0", 32'(rdata0), 32'(exp_rd0));
        check("rdata1", 32'(rdata1), 32'(exp_rd1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, 32'(gnt0), 32'(0));
        check({tag, "_gnt1"}, 32'(gnt1), 32'(0));
        check({tag, "_rvalid0"}, 32'(rvalid0), 32'(0));
        check({tag, "_rvalid1"}, 32'(rvalid1), 32'(0));
        check({tag, "_rdata0"}, 32'(rdata0), 32'(0));
        check({tag, "_rdata1"}, 32'(rdata1), 32'(0));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_port(input int p, input bit r, input bit l, input bit w,
                            input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // A requester left waiting keeps its beat unchanged.
    task automatic rand_inputs();
        if (!(req0 && prev_win != 0))
            set_port(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), 8'($urandom));
        if (!(req1 && prev_win != 1))
            set_port(1, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        model_reset();
        #2 check_reset_outputs("rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        ram_load = 1'b0;

        // Single read with latency check
        set_port(0, 1, 0, 0, 8'h10, 8'h00);
        step();
        set_port(0, 0, 0, 0, 8'h10, 8'h00);
        step();
        check("tp_rdata0", 32'(rdata0), 32'h5A);
        step();

        // Round-robin with continuous reads on both ports
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1, 0, 0, 8'(i), 8'h00);
            set_port(1, 1, 0, 0, 8'(i + 32), 8'h00);
            step();
        end

        // Locked burst from port 1 longer than MAX_BURST while port 0 waits
        set_port(0, 1, 0, 0, 8'h40, 8'h00);
        for (int i = 0; i < 9; i++) begin
            set_port(1, 1, 1, 0, 8'(i + 64), 8'h00);
            step();
        end
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        step();

        // Early release: port 0 locks, then drops its request
        set_port(0, 1, 1, 0, 8'h05, 8'h00);
        step();
        set_port(0, 1, 1, 0, 8'h06, 8'h00);
        set_port(1, 1, 0, 0, 8'h07, 8'h00);
        step();
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        step();
        step();
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        // Lock released by a beat with lock0 low
        set_port(0, 1, 1, 0, 8'h08, 8'h00);
        step();
        set_port(0, 1, 0, 0, 8'h09, 8'h00);
        set_port(1, 1, 0, 0, 8'h0A, 8'h00);
        step();
        step();
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        step();

        // Write then read of the same address on the next beat
        set_port(0, 1, 0, 1, 8'hF2, 8'hA3);
        step();
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 1, 0, 0, 8'hF2, 8'h00);
        step();
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        step();
        check("tp_rdata1", 32'(rdata1), 32'hA3);
        step();

        // Reset during a locked burst with a read in flight
        set_port(1, 1, 1, 0, 8'h20, 8'h00);
        step();
        step();
        do_reset();
        set_port(0, 1, 0, 0, 8'h21, 8'h00);
        set_port(1, 1, 0, 0, 8'h22, 8'h00);
        step();
        check("post_rst_first", 32'(prev_win), 32'(0));
        step();
        step();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
            if (i == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
